axis_channel_packer: RTL and testbench
======================================

Name: axis_channel_packer

Overview:
- Consumes the six selected streams produced by the axis_selector crossbar (M_AXIS_1..6).
- Takes periodic snapshots of all six at a programmable decimation rate.
- Serialises each snapshot into one backpressured AXI-Stream frame (header word plus enabled channels, tlast on the final beat) for the DMA/FIFO path to the PS.
- This is the consuming end of the selector outputs: the selector fans streams out, this block gathers them into one.

Parameters:
- TDATA_WIDTH, 32: width of all input and output tdata; must be >= 32.
- N_CH, 6: channel count; fixed at 6 for this revision. The ports are explicit.

Ports:
- a_clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- S_AXIS_1..6_tdata  in  TDATA_WIDTH  channel data. Free-running, no tready.
- S_AXIS_1..6_tvalid  in  1  channel valid. Sampled into the header only.
- enable  in  1  run control.
- decimation  in  32  snapshot period minus 1, in a_clk cycles.
- channel_mask  in  6  bit i set means channel i+1 is included in the frame.
- M_AXIS_tdata  out  TDATA_WIDTH  output beat.
- M_AXIS_tvalid  out  1  output valid.
- M_AXIS_tready  in  1  downstream ready.
- M_AXIS_tlast  out  1  last beat of a frame.
- M_AXIS_tuser  out  3  beat id: 0 = header, 1..6 = channel number.
- frame_count  out  32  number of frames fully sent. Wraps.
- overrun_count  out  16  number of snapshots dropped. Saturates at 0xFFFF.

Behaviour:
- Reset:
  - All outputs 0, state IDLE, decimation counter 0.
  - Snapshot registers 0.
  - Reset mid-frame aborts the frame immediately; no tlast is emitted.
- Decimation counter:
  - Runs only while enable=1. When enable=0 it is held at 0.
  - tick=1 when counter >= decimation; the counter then reloads 0, otherwise it increments.
  - decimation=0 gives a tick every cycle.
  - Lowering decimation below the current count gives a tick on the next cycle.
- Snapshot on tick, accepted when state is IDLE, or when the last beat handshakes in the same cycle:
  - Latch all six tdata values.
  - Latch tvalid bits as vmask[5:0].
  - Latch channel_mask as cmask.
  - Go to HDR.
- Tick while busy and not on the last handshake: snapshot dropped, overrun_count += 1 (saturating).
- Latency: tick in cycle t gives the header with M_AXIS_tvalid=1 in cycle t+1.
- HDR state:
  - Header tdata[31:16] = frame_count[15:0], [13:8] = vmask, [5:0] = cmask; all other bits 0.
  - tuser = 0.
  - tlast = 1 if cmask == 0.
- DATA state:
  - Emits channels whose cmask bit is set, in ascending index order.
  - tdata = latched value, tuser = channel number.
  - tlast on the highest enabled channel.
  - Next-channel index comes from a priority search over the remaining mask bits; no idle cycles between beats.
- Handshake:
  - A beat advances only when tvalid && tready.
  - tdata, tuser and tlast stay stable while tvalid && !tready.
  - tvalid never drops before its handshake.
- frame_count increments on the tlast handshake.
- enable falling mid-frame: the current frame completes normally; no new ticks occur.
- Register changes:
  - channel_mask and decimation changes never affect a frame in flight; cmask is latched.
  - Inputs changing after the snapshot do not affect the frame.
- Sustained throughput: frame length is 1 + popcount(cmask) beats. If decimation+1 is smaller than that, overruns are expected and counted.

Decomposition:
- Shared package (rpspmc_axis_pkg) holds:
  - the state enum (IDLE, HDR, DATA);
  - the header bit-field offsets (FC_LSB=16, VMASK_LSB=8, CMASK_LSB=0);
  - TUSER_HDR = 0;
  - OVR_MAX = 16'hFFFF.
- One natural sub-module, axis_decim_tick: the decimation counter and tick generation, with enable and reset.

Test Plan:
1. decimation=9, mask=6'b000101, tready=1, enable=1:
   - Required: a frame every 10 cycles.
   - Beats: header, ch1 (tuser=1), ch3 (tuser=3, tlast=1).
   - overrun_count stays 0; frame_count increments by 1 per frame.
2. mask=0, decimation=0, tready=1:
   - Required: a header-only frame every cycle, each with tlast=1.
   - The tick coinciding with the last handshake is accepted; overrun_count=0.
3. mask=6'h3F, decimation=3, tready=1:
   - Frame is 7 beats against a 4-cycle period.
   - Required: overrun_count +1 per frame after the first.
   - Frames remain intact, 7 beats each, in order.
4. tready toggled 1-0-0-1 during a frame:
   - Required: tdata, tuser and tlast held stable while tready=0.
   - No beat lost or duplicated.
   - Header fields match: e.g. vmask=6'b111111 when all tvalid=1.
5. Reset asserted during ch2 of a frame:
   - Required: next cycle all outputs 0, tvalid=0, frame_count=0, overrun_count=0.
   - After reset is released, the first frame starts 1 cycle after the next tick.
6. Force overruns past 65535 drops:
   - Required: overrun_count saturates at 16'hFFFF.
   - Additionally, with enable dropped mid-frame, the frame finishes with tlast and no further frames follow.

Source files
------------

// File: rtl/axis_channel_packer_pkg.sv
// Shared state type, header layout and helpers for the channel packer.
package rpspmc_axis_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_t;

    localparam int          N_CH      = 6;
    localparam int          FC_LSB    = 16;
    localparam int          VMASK_LSB = 8;
    localparam int          CMASK_LSB = 0;
    localparam logic [2:0]  TUSER_HDR = 3'd0;
    localparam logic [15:0] OVR_MAX   = 16'hFFFF;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [2:0] lowest_set(input logic [N_CH-1:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_channel_packer_if.sv
// Backpressured AXI-Stream bus carrying the packed frames.
interface axis_channel_packer_if #(
    parameter int TDATA_WIDTH = 32
);
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic [2:0]             tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_channel_packer_decim_tick.sv
// Decimation counter: one tick every decimation+1 cycles while enabled.
module axis_decim_tick
    import rpspmc_axis_pkg::*;
(
    input  logic        a_clk,
    input  logic        reset,
    input  logic        i_enable,
    input  logic [31:0] i_decimation,
    output logic        o_tick
);
    logic [31:0] r_cnt;
    logic        w_due;

    // >= rather than == so a lowered decimation fires on the next cycle.
    assign w_due  = (r_cnt >= i_decimation);
    assign o_tick = i_enable && w_due;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge a_clk) begin
        if (reset || !i_enable) begin
            r_cnt <= '0;
        end else if (w_due) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end
endmodule

// File: rtl/axis_channel_packer.sv
// Snapshots six free-running channels on each tick and serialises them as one frame.
module axis_channel_packer
    import rpspmc_axis_pkg::*;
#(
    parameter int TDATA_WIDTH = 32
) (
    input  logic                   a_clk,
    input  logic                   reset,
    input  logic [TDATA_WIDTH-1:0] S_AXIS_1_tdata,
    input  logic [TDATA_WIDTH-1:0] S_AXIS_2_tdata,
    input  logic [TDATA_WIDTH-1:0] S_AXIS_3_tdata,
    input  logic [TDATA_WIDTH-1:0] S_AXIS_4_tdata,
    input  logic [TDATA_WIDTH-1:0] S_AXIS_5_tdata,
    input  logic [TDATA_WIDTH-1:0] S_AXIS_6_tdata,
    input  logic                   S_AXIS_1_tvalid,
    input  logic                   S_AXIS_2_tvalid,
    input  logic                   S_AXIS_3_tvalid,
    input  logic                   S_AXIS_4_tvalid,
    input  logic                   S_AXIS_5_tvalid,
    input  logic                   S_AXIS_6_tvalid,
    input  logic                   enable,
    input  logic [31:0]            decimation,
    input  logic [5:0]             channel_mask,
    axis_channel_packer_if.master  M_AXIS,
    output logic [31:0]            frame_count,
    output logic [15:0]            overrun_count
);
    state_t                 r_state, w_next;
    logic [TDATA_WIDTH-1:0] r_snap [N_CH];
    logic [N_CH-1:0]        r_vmask, r_cmask, r_rem;
    logic [31:0]            r_frames;
    logic [15:0]            r_ovr;

    logic [TDATA_WIDTH-1:0] w_in [N_CH];
    logic [N_CH-1:0]        w_in_valid, w_rem_after;
    logic [TDATA_WIDTH-1:0] w_hdr, w_tdata;
    logic [2:0]             w_ch, w_tuser;
    logic                   w_tick, w_tvalid, w_tlast, w_hs, w_last_hs, w_accept;

    assign w_in[0]    = S_AXIS_1_tdata;
    assign w_in[1]    = S_AXIS_2_tdata;
    assign w_in[2]    = S_AXIS_3_tdata;
    assign w_in[3]    = S_AXIS_4_tdata;
    assign w_in[4]    = S_AXIS_5_tdata;
    assign w_in[5]    = S_AXIS_6_tdata;
    assign w_in_valid = {S_AXIS_6_tvalid, S_AXIS_5_tvalid, S_AXIS_4_tvalid,
                         S_AXIS_3_tvalid, S_AXIS_2_tvalid, S_AXIS_1_tvalid};

    axis_decim_tick u_tick (
        .a_clk        (a_clk),
        .reset        (reset),
        .i_enable     (enable),
        .i_decimation (decimation),
        .o_tick       (w_tick)
    );

    // Current channel is the lowest bit still pending in the latched mask.
    assign w_ch        = lowest_set(r_rem);
    assign w_rem_after = r_rem & ~({{(N_CH-1){1'b0}}, 1'b1} << w_ch);

    always_comb begin
        w_hdr                     = '0;
        w_hdr[FC_LSB +: 16]       = r_frames[15:0];
        w_hdr[VMASK_LSB +: N_CH]  = r_vmask;
        w_hdr[CMASK_LSB +: N_CH]  = r_cmask;
    end

    always_ff @(posedge a_clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next   = r_state;
        w_tvalid = 1'b0;
        w_tdata  = '0;
        w_tuser  = TUSER_HDR;
        w_tlast  = 1'b0;
        case (r_state)
            HDR: begin
                w_tvalid = 1'b1;
                w_tdata  = w_hdr;
                w_tlast  = (r_cmask == '0);
            end
            DATA: begin
                w_tvalid = 1'b1;
                w_tdata  = r_snap[w_ch];
                w_tuser  = w_ch + 3'd1;
                w_tlast  = (w_rem_after == '0);
            end
            default: ;
        endcase
        w_hs      = w_tvalid && M_AXIS.tready;
        w_last_hs = w_hs && w_tlast;
        // A tick is taken when idle or when the frame ends in this very cycle.
        w_accept  = w_tick && ((r_state == IDLE) || w_last_hs);
        if (w_accept)                      w_next = HDR;
        else if (w_last_hs)                w_next = IDLE;
        else if (w_hs && r_state == HDR)   w_next = DATA;
    end

    // NOTE: the six snapshot words are plain registers, so they are reset with the rest.
    always_ff @(posedge a_clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) r_snap[i] <= '0;
            r_vmask  <= '0;
            r_cmask  <= '0;
            r_rem    <= '0;
            r_frames <= '0;
            r_ovr    <= '0;
        end else begin
            if (w_accept) begin
                r_snap  <= w_in;
                r_vmask <= w_in_valid;
                r_cmask <= channel_mask;
                r_rem   <= channel_mask;
            end else if (w_hs && r_state == DATA) begin
                r_rem <= w_rem_after;
            end
            if (w_last_hs) r_frames <= r_frames + 32'd1;
            if (w_tick && !w_accept && r_ovr != OVR_MAX) r_ovr <= r_ovr + 16'd1;
        end
    end

    assign M_AXIS.tvalid = w_tvalid;
    assign M_AXIS.tdata  = w_tdata;
    assign M_AXIS.tuser  = w_tuser;
    assign M_AXIS.tlast  = w_tlast;
    assign frame_count   = r_frames;
    assign overrun_count = r_ovr;
endmodule

// File: tb/tb_axis_channel_packer.sv
// Randomised bench for axis_channel_packer against a frame-queue reference model.
module tb_axis_channel_packer;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   user;
        logic         last;
    } beat_t;

    logic         a_clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [31:0]  decimation = '0;
    logic [5:0]   channel_mask = '0;
    logic [W-1:0] s_data [6];
    logic [5:0]   s_valid;
    logic [31:0]  frame_count;
    logic [15:0]  overrun_count;

    int tready_mode = 0;
    bit force_valid = 1'b0;
    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: the beats still owed for the frame in flight.
    beat_t       q[$];
    logic [31:0] m_fc = '0;
    logic [15:0] m_oc = '0;
    logic [31:0] m_elapsed = '0;

    axis_channel_packer_if #(.TDATA_WIDTH(W)) m_axis ();

    axis_channel_packer #(.TDATA_WIDTH(W)) dut (
        .a_clk          (a_clk),
        .reset          (reset),
        .S_AXIS_1_tdata (s_data[0]),
        .S_AXIS_2_tdata (s_data[1]),
        .S_AXIS_3_tdata (s_data[2]),
        .S_AXIS_4_tdata (s_data[3]),
        .S_AXIS_5_tdata (s_data[4]),
        .S_AXIS_6_tdata (s_data[5]),
        .S_AXIS_1_tvalid(s_valid[0]),
        .S_AXIS_2_tvalid(s_valid[1]),
        .S_AXIS_3_tvalid(s_valid[2]),
        .S_AXIS_4_tvalid(s_valid[3]),
        .S_AXIS_5_tvalid(s_valid[4]),
        .S_AXIS_6_tvalid(s_valid[5]),
        .enable         (enable),
        .decimation     (decimation),
        .channel_mask   (channel_mask),
        .M_AXIS         (m_axis),
        .frame_count    (frame_count),
        .overrun_count  (overrun_count)
    );

    always #5 a_clk = ~a_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event never seen within its cycle budget (t=%0t)", name, $time);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge a_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        step(2);
        reset  = 1'b0;
    endtask

    // Steps until tvalid is seen; n = steps taken, -1 if the budget ran out.
    task automatic steps_to_valid(input int budget, output int n);
        n = 0;
        while (!m_axis.tvalid && n < budget) begin
            step();
            n++;
        end
        if (!m_axis.tvalid) n = -1;
    endtask

    // Frame = header word, then each enabled channel in ascending order.
    function automatic void build_frame();
        beat_t b;
        int    hi;
        hi = -1;
        for (int i = 0; i < 6; i++) if (channel_mask[i]) hi = i;
        b.data = {m_fc[15:0], 2'b00, s_valid, 2'b00, channel_mask};
        b.user = 3'd0;
        b.last = (hi < 0);
        q.push_back(b);
        for (int i = 0; i < 6; i++) begin
            if (channel_mask[i]) begin
                b.data = s_data[i];
                b.user = 3'(i + 1);
                b.last = (i == hi);
                q.push_back(b);
            end
        end
    endfunction

    // Free-running sources and downstream ready, changed just after each edge.
    always @(posedge a_clk) begin
        #1;
        cyc++;
        for (int i = 0; i < 6; i++) s_data[i] = $urandom;
        s_valid = force_valid ? 6'h3F : 6'($urandom);
        case (tready_mode)
            0:       m_axis.tready = 1'b1;
            1:       m_axis.tready = 1'($urandom_range(0, 1));
            2:       m_axis.tready = ((cyc % 4) inside {1, 2}) ? 1'b0 : 1'b1;
            default: m_axis.tready = 1'b0;
        endcase
    end

    // Compare on the falling edge, then advance the model across the next rising edge.
    always @(negedge a_clk) begin
        beat_t b;
        bit    ev;
        ev = (q.size() != 0);
        check("tvalid", m_axis.tvalid, ev);
        if (ev) begin
            check("tdata", m_axis.tdata, q[0].data);
            check("tuser", m_axis.tuser, q[0].user);
            check("tlast", m_axis.tlast, q[0].last);
        end
        check("frame_count", frame_count, m_fc);
        check("overrun_count", overrun_count, m_oc);
        if (reset) begin
            q.delete();
            m_fc      = '0;
            m_oc      = '0;
            m_elapsed = '0;
        end else begin
            if (ev && m_axis.tready) begin
                b = q.pop_front();
                if (b.last) m_fc++;
            end
            if (enable && m_elapsed >= decimation) begin
                m_elapsed = '0;
                if (q.size() == 0) build_frame();
                else if (m_oc != 16'hFFFF) m_oc++;
            end else begin
                m_elapsed = enable ? m_elapsed + 32'd1 : 32'd0;
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 6; i++) s_data[i] = '0;

        // 1: mask 000101, decimation 9, all sources valid.
        force_valid  = 1'b1;
        decimation   = 32'd9;
        channel_mask = 6'b000101;
        do_reset();
        enable = 1'b1;
        steps_to_valid(40, n);
        if (n < 0) timeout("t1_first_header");
        else begin
            check("t1_first_latency", n, 10);
            check("t1_header_word", m_axis.tdata, 32'h0000_3F05);
        end
        step(90);
        check("t1_frames_after_100", frame_count, 9);
        check("t1_overruns", overrun_count, 0);

        // 2: header-only frames every cycle.
        force_valid  = 1'b0;
        channel_mask = 6'b000000;
        decimation   = 32'd0;
        do_reset();
        enable = 1'b1;
        step(50);
        check("t2_frames_after_50", frame_count, 49);
        check("t2_overruns", overrun_count, 0);

        // 3: 7-beat frames against a 4-cycle period.
        channel_mask = 6'h3F;
        decimation   = 32'd3;
        do_reset();
        enable = 1'b1;
        n = 0;
        while (frame_count != 32'd4 && n < 200) begin
            step();
            n++;
        end
        if (frame_count != 32'd4) timeout("t3_four_frames");
        else check("t3_overruns_at_4_frames", overrun_count, 4);

        // 4: tready 1-0-0-1 pattern, then random backpressure with live register changes.
        force_valid  = 1'b1;
        channel_mask = 6'h3F;
        decimation   = 32'd20;
        tready_mode  = 2;
        do_reset();
        enable = 1'b1;
        steps_to_valid(40, n);
        if (n < 0) timeout("t4_header");
        else begin
            check("t4_hdr_vmask", m_axis.tdata[13:8], 6'h3F);
            check("t4_hdr_cmask", m_axis.tdata[5:0], 6'h3F);
            check("t4_hdr_tuser", m_axis.tuser, 0);
        end
        step(150);
        force_valid = 1'b0;
        tready_mode = 1;
        for (int k = 0; k < 120; k++) begin
            channel_mask = 6'($urandom);
            decimation   = 32'($urandom_range(0, 12));
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            step(10);
        end

        // 5: reset in the middle of channel 2.
        tready_mode  = 0;
        channel_mask = 6'h3F;
        decimation   = 32'd20;
        do_reset();
        enable = 1'b1;
        n = 0;
        while (!(m_axis.tvalid && m_axis.tuser == 3'd2) && n < 60) begin
            step();
            n++;
        end
        if (!(m_axis.tvalid && m_axis.tuser == 3'd2)) timeout("t5_reach_ch2");
        reset = 1'b1;
        step();
        check("t5_tvalid", m_axis.tvalid, 0);
        check("t5_tdata", m_axis.tdata, 0);
        check("t5_tuser", m_axis.tuser, 0);
        check("t5_tlast", m_axis.tlast, 0);
        check("t5_frame_count", frame_count, 0);
        check("t5_overrun_count", overrun_count, 0);
        reset = 1'b0;
        steps_to_valid(60, n);
        if (n < 0) timeout("t5_restart");
        else begin
            check("t5_restart_latency", n, 21);
            check("t5_restart_tuser", m_axis.tuser, 0);
        end

        // 6: stall downstream until the overrun counter saturates, then drain with enable low.
        channel_mask = 6'h3F;
        decimation   = 32'd0;
        tready_mode  = 3;
        do_reset();
        enable = 1'b1;
        step(65545);
        check("t6_overrun_saturated", overrun_count, 16'hFFFF);
        tready_mode = 0;
        enable      = 1'b0;
        n = 0;
        while (!(m_axis.tvalid && m_axis.tlast) && n < 30) begin
            step();
            n++;
        end
        if (!(m_axis.tvalid && m_axis.tlast)) timeout("t6_final_tlast");
        step(30);
        check("t6_one_frame_done", frame_count, 1);
        check("t6_idle_after_drain", m_axis.tvalid, 0);
        check("t6_overrun_held", overrun_count, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
